// File: rtl/add_acc_pipe_if.sv
// Operand/result bundle for add_acc_pipe: the valid-qualified operand pair in,
// the registered sum/accumulator state out.
interface add_acc_pipe_if #(
    parameter int WIDTH = 4,
    parameter int ACC_W = 8,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [1:0]       mode;
    logic             out_valid;
    logic [WIDTH:0]   sum;
    logic             sat;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic [CNT_W-1:0] op_count;

    modport master (
        output in_valid, x, y, mode,
        input  out_valid, sum, sat, acc, ovf, op_count
    );

    modport slave (
        input  in_valid, x, y, mode,
        output out_valid, sum, sat, acc, ovf, op_count
    );
endinterface

// File: rtl/add_acc_pipe.sv
// Registered W-bit adder with saturating-add mode, a saturating accumulator
// with sticky overflow, and an accepted-operation counter. One cycle latency.
module add_acc_pipe #(
    parameter int WIDTH = 4,
    parameter int ACC_W = 8,   // must be >= WIDTH+1
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    add_acc_pipe_if.slave bus
);
    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_ACC = 2'b01;
    localparam logic [1:0] MODE_SAT = 2'b10;
    localparam logic [1:0] MODE_CLR = 2'b11;

    logic             out_valid_q;
    logic [WIDTH:0]   sum_q;
    logic             sat_q;
    logic [ACC_W-1:0] acc_q;
    logic             ovf_q;
    logic [CNT_W-1:0] op_count_q;

    logic [WIDTH:0]   raw_sum;
    logic [ACC_W+1:0] acc_t;
    logic             acc_over;

    // Two guard bits above the accumulator so acc + x + y can never wrap.
    always_comb begin
        raw_sum  = {1'b0, bus.x} + {1'b0, bus.y};
        acc_t    = {2'b00, acc_q}
                 + {{(ACC_W+2-WIDTH){1'b0}}, bus.x}
                 + {{(ACC_W+2-WIDTH){1'b0}}, bus.y};
        acc_over = (acc_t[ACC_W+1:ACC_W] != 2'b00);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            sat_q       <= 1'b0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            op_count_q  <= '0;
        end else if (bus.in_valid) begin
            out_valid_q <= 1'b1;
            op_count_q  <= op_count_q + CNT_W'(1);
            sum_q       <= raw_sum;
            sat_q       <= 1'b0;
            case (bus.mode)
                MODE_ACC: begin
                    if (acc_over) begin
                        acc_q <= '1;
                        ovf_q <= 1'b1;
                    end else begin
                        acc_q <= acc_t[ACC_W-1:0];
                    end
                end
                MODE_SAT: begin
                    if (raw_sum[WIDTH]) begin
                        sum_q <= {1'b0, {WIDTH{1'b1}}};
                        sat_q <= 1'b1;
                    end
                end
                MODE_CLR: begin
                    acc_q <= '0;
                    ovf_q <= 1'b0;
                end
                MODE_ADD: ;
                default: ;
            endcase
        end else begin
            // Idle: operands are don't-care, only the strobes drop.
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.sat       = sat_q;
    assign bus.acc       = acc_q;
    assign bus.ovf       = ovf_q;
    assign bus.op_count  = op_count_q;
endmodule

// File: tb/tb_add_acc_pipe.sv
// Directed + random bench for add_acc_pipe with WIDTH=4, ACC_W=6, CNT_W=4;
// expected results are queued at drive time and compared one cycle later.
module tb_add_acc_pipe;
    localparam int WIDTH = 4;
    localparam int ACC_W = 6;
    localparam int CNT_W = 4;

    typedef struct {
        logic [WIDTH:0]   sum;
        logic             sat;
        logic [ACC_W-1:0] acc;
        logic             ovf;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    add_acc_pipe_if #(.WIDTH(WIDTH), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    add_acc_pipe #(.WIDTH(WIDTH), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    exp_t             sb[$];
    logic [WIDTH:0]   m_sum;
    logic [ACC_W-1:0] m_acc;
    logic             m_ovf;
    logic [CNT_W-1:0] m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_cycle();
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("out_valid", 32'(bus.out_valid), 32'd1);
            chk("sum", 32'(bus.sum), 32'(e.sum));
            chk("sat", 32'(bus.sat), 32'(e.sat));
            chk("acc", 32'(bus.acc), 32'(e.acc));
            chk("ovf", 32'(bus.ovf), 32'(e.ovf));
            chk("op_count", 32'(bus.op_count), 32'(e.cnt));
        end else begin
            chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
            chk("idle_sat", 32'(bus.sat), 32'd0);
            chk("idle_sum_hold", 32'(bus.sum), 32'(m_sum));
            chk("idle_acc_hold", 32'(bus.acc), 32'(m_acc));
            chk("idle_ovf_hold", 32'(bus.ovf), 32'(m_ovf));
            chk("idle_cnt_hold", 32'(bus.op_count), 32'(m_cnt));
        end
    endtask

    // One clock: drive (or idle with X operands), update model, compare after the edge.
    task automatic send(input logic v, input logic [1:0] md, input logic [3:0] a, input logic [3:0] b);
        int   s;
        int   t;
        logic m_sat;
        exp_t e;
        reset = 1'b0;
        bus.in_valid = v;
        if (v) begin
            bus.mode = md;
            bus.x    = a;
            bus.y    = b;
            s = a + b;
            m_sum = s[WIDTH:0];
            m_sat = 1'b0;
            case (md)
                2'b01: begin
                    t = m_acc + a + b;
                    if (t > 63) begin
                        m_acc = 6'h3F;
                        m_ovf = 1'b1;
                    end else begin
                        m_acc = t[ACC_W-1:0];
                    end
                end
                2'b10: begin
                    if (s > 15) begin
                        m_sum = 5'h0F;
                        m_sat = 1'b1;
                    end
                end
                2'b11: begin
                    m_acc = '0;
                    m_ovf = 1'b0;
                end
                default: ;
            endcase
            m_cnt = m_cnt + 4'd1;
            e = '{sum: m_sum, sat: m_sat, acc: m_acc, ovf: m_ovf, cnt: m_cnt};
            sb.push_back(e);
        end else begin
            bus.mode = 'x;
            bus.x    = 'x;
            bus.y    = 'x;
        end
        @(posedge clk);
        #1;
        check_cycle();
    endtask

    task automatic do_reset(input logic with_op);
        reset = 1'b1;
        bus.in_valid = with_op;
        bus.mode = 2'b01;
        bus.x    = 4'd15;
        bus.y    = 4'd15;
        m_sum = '0;
        m_acc = '0;
        m_ovf = 1'b0;
        m_cnt = '0;
        sb.delete();
        @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_sat", 32'(bus.sat), 32'd0);
        chk("rst_acc", 32'(bus.acc), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        chk("rst_op_count", 32'(bus.op_count), 32'd0);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        logic [1:0] md;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.mode = 2'b00;
        bus.x = '0;
        bus.y = '0;

        // 1: reset, basic ADD with full carry, idle hold
        do_reset(1'b0);
        do_reset(1'b0);
        send(1'b1, 2'b00, 4'd9, 4'd8);
        chk("add_9_8", 32'(bus.sum), 32'h11);
        send(1'b0, 2'b00, 4'd0, 4'd0);
        chk("add_hold", 32'(bus.sum), 32'h11);

        // 2: saturating add, clipping and non-clipping
        send(1'b1, 2'b10, 4'd15, 4'd15);
        chk("sat_clip_sum", 32'(bus.sum), 32'h0F);
        chk("sat_clip_flag", 32'(bus.sat), 32'd1);
        send(1'b1, 2'b10, 4'd3, 4'd4);
        chk("sat_noclip_sum", 32'(bus.sum), 32'h07);
        chk("sat_noclip_flag", 32'(bus.sat), 32'd0);

        // 3: accumulate to saturation, sticky ovf, ADD leaves acc alone
        send(1'b1, 2'b01, 4'd15, 4'd15);
        chk("acc_30", 32'(bus.acc), 32'd30);
        send(1'b1, 2'b01, 4'd15, 4'd15);
        chk("acc_60", 32'(bus.acc), 32'd60);
        send(1'b1, 2'b01, 4'd15, 4'd15);
        chk("acc_63", 32'(bus.acc), 32'd63);
        chk("acc_ovf", 32'(bus.ovf), 32'd1);
        send(1'b1, 2'b00, 4'd2, 4'd2);
        send(1'b1, 2'b01, 4'd1, 4'd0);
        chk("acc_stuck", 32'(bus.acc), 32'd63);
        chk("ovf_sticky", 32'(bus.ovf), 32'd1);

        // 4: clear, then accumulate again
        send(1'b1, 2'b11, 4'd2, 4'd3);
        chk("clr_sum", 32'(bus.sum), 32'd5);
        chk("clr_acc", 32'(bus.acc), 32'd0);
        chk("clr_ovf", 32'(bus.ovf), 32'd0);
        send(1'b1, 2'b01, 4'd1, 4'd1);
        chk("acc_after_clr", 32'(bus.acc), 32'd2);

        // 5: reset wins over a valid op
        send(1'b1, 2'b01, 4'd15, 4'd15);
        send(1'b1, 2'b01, 4'd3, 4'd3);
        send(1'b1, 2'b01, 4'd1, 4'd1);
        chk("acc_40", 32'(bus.acc), 32'd40);
        do_reset(1'b1);
        send(1'b0, 2'b00, 4'd0, 4'd0);

        // 6: counter wrap and random ADD/SAT
        do_reset(1'b0);
        for (int i = 1; i <= 16; i++) begin
            send(1'b1, 2'b00, 4'(i), 4'(15 - i));
            chk("cnt_seq", 32'(bus.op_count), 32'(i % 16));
        end
        for (int i = 0; i < 100; i++) begin
            md = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b10;
            send(1'b1, md, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0)
                send(1'b0, 2'b00, 4'd0, 4'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
